// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_unit_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 16;

endpackage : hazard_ctrl_unit_pkg

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for perf counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: memory stall, branch flush and load-use bubble
// steering, plus memory-timeout watchdog and stall/flush perf counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RD_i,
  input  logic [4:0]       IF_ID_RS_i,
  input  logic [4:0]       IF_ID_RT_i,
  input  logic             IF_ID_UsesRT_i,
  input  logic             Branch_taken_i,
  input  logic             EX_MEM_MemAccess_i,
  input  logic             DMEM_ready_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Write_o,
  output logic             ID_EX_Flush_o,
  output logic             EX_MEM_Write_o,
  output logic             MEM_WB_Bubble_o,
  output logic             Mem_timeout_o,
  output logic [CNT_W-1:0] Stall_cnt_o,
  output logic [CNT_W-1:0] Flush_cnt_o
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              load_bubble_q, load_bubble_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              mem_stall, load_use, load_use_eff;

  assign mem_stall    = EX_MEM_MemAccess_i && !DMEM_ready_i;
  assign load_use     = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
                        ((ID_EX_RD_i == IF_ID_RS_i) ||
                         (IF_ID_UsesRT_i && (ID_EX_RD_i == IF_ID_RT_i)));
  // The load whose bubble was just inserted is still seen by ID next cycle.
  assign load_use_eff = load_use && !load_bubble_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    PC_Write_o      = 1'b1;
    IF_ID_Write_o   = 1'b1;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Write_o   = 1'b1;
    ID_EX_Flush_o   = 1'b0;
    EX_MEM_Write_o  = 1'b1;
    MEM_WB_Bubble_o = 1'b0;
    if (mem_stall) begin
      PC_Write_o      = 1'b0;
      IF_ID_Write_o   = 1'b0;
      ID_EX_Write_o   = 1'b0;
      EX_MEM_Write_o  = 1'b0;
      MEM_WB_Bubble_o = 1'b1;
    end else if (Branch_taken_i) begin
      IF_ID_Flush_o = 1'b1;
      ID_EX_Flush_o = 1'b1;
    end else if (load_use_eff) begin
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
      ID_EX_Flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    // The bubble mark survives a memory freeze, since the pipeline does not advance.
    load_bubble_d = mem_stall ? load_bubble_q : (!Branch_taken_i && load_use_eff);
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == WAIT_MAX) mem_timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      load_bubble_q <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      load_bubble_q <= load_bubble_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign Mem_timeout_o = mem_timeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (!PC_Write_o),
    .count_o (Stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (IF_ID_Flush_o),
    .count_o (Flush_cnt_o)
  );

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl_unit;

  localparam int MEM_TIMEOUT = 255;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct {
    logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bub, tmo;
    int   stall_cnt, flush_cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             id_ex_memread = 1'b0;
  logic [4:0]       id_ex_rd = '0, if_id_rs = '0, if_id_rt = '0;
  logic             if_id_usesrt = 1'b0, branch_taken = 1'b0;
  logic             ex_mem_access = 1'b0, dmem_ready = 1'b1;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic             ex_mem_write, mem_wb_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .ID_EX_MemRead_i    (id_ex_memread),
    .ID_EX_RD_i         (id_ex_rd),
    .IF_ID_RS_i         (if_id_rs),
    .IF_ID_RT_i         (if_id_rt),
    .IF_ID_UsesRT_i     (if_id_usesrt),
    .Branch_taken_i     (branch_taken),
    .EX_MEM_MemAccess_i (ex_mem_access),
    .DMEM_ready_i       (dmem_ready),
    .PC_Write_o         (pc_write),
    .IF_ID_Write_o      (if_id_write),
    .IF_ID_Flush_o      (if_id_flush),
    .ID_EX_Write_o      (id_ex_write),
    .ID_EX_Flush_o      (id_ex_flush),
    .EX_MEM_Write_o     (ex_mem_write),
    .MEM_WB_Bubble_o    (mem_wb_bubble),
    .Mem_timeout_o      (mem_timeout),
    .Stall_cnt_o        (stall_cnt),
    .Flush_cnt_o        (flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // Reference model state: behaviour expressed as pipeline-level facts.
  bit m_bubble_pending;   // previous advancing cycle already inserted a load-use bubble
  int m_stall_run;        // consecutive memory-stall cycles so far
  bit m_tmo;
  int m_stall_cnt, m_flush_cnt;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bubble_pending = 1'b0;
    m_stall_run      = 0;
    m_tmo            = 1'b0;
    m_stall_cnt      = 0;
    m_flush_cnt      = 0;
  endtask

  function automatic exp_t model_outputs(input logic acc, rdy, br, mr,
                                         input logic [4:0] rd, rs, rt, input logic urt);
    exp_t e;
    bit   ms, lu;
    ms = acc && !rdy;
    lu = mr && rd != 0 && (rd == rs || (urt && rd == rt)) && !m_bubble_pending;
    e = '{pc_w: 1, ifid_w: 1, ifid_f: 0, idex_w: 1, idex_f: 0, exmem_w: 1, bub: 0,
          tmo: m_tmo, stall_cnt: m_stall_cnt, flush_cnt: m_flush_cnt};
    if (ms) begin
      e.pc_w = 0; e.ifid_w = 0; e.idex_w = 0; e.exmem_w = 0; e.bub = 1;
    end else if (br) begin
      e.ifid_f = 1; e.idex_f = 1;
    end else if (lu) begin
      e.pc_w = 0; e.ifid_w = 0; e.idex_f = 1;
    end
    return e;
  endfunction

  task automatic drive(input logic acc, rdy, br, mr, input logic [4:0] rd, rs, rt,
                       input logic urt);
    ex_mem_access = acc; dmem_ready = rdy; branch_taken = br; id_ex_memread = mr;
    id_ex_rd = rd; if_id_rs = rs; if_id_rt = rt; if_id_usesrt = urt;
  endtask

  // One clocked cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic acc, rdy, br, mr, input logic [4:0] rd, rs, rt,
                      input logic urt);
    exp_t e;
    bit   ms;
    drive(acc, rdy, br, mr, rd, rs, rt, urt);
    e  = model_outputs(acc, rdy, br, mr, rd, rs, rt, urt);
    ms = acc && !rdy;
    exp_q.push_back(e);
    m_stall_run = ms ? m_stall_run + 1 : 0;
    if (m_stall_run >= MEM_TIMEOUT + 1) m_tmo = 1'b1;
    if (!ms) m_bubble_pending = !br && !e.pc_w;
    if (!e.pc_w && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (e.ifid_f && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic acc, rdy, br, mr, input logic [4:0] rd, rs, rt,
                          input logic urt);
    rst_ni = 1'b0;
    model_reset();
    drive(acc, rdy, br, mr, rd, rs, rt, urt);
    exp_q.push_back(model_outputs(acc, rdy, br, mr, rd, rs, rt, urt));
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("PC_Write",      pc_write,      e.pc_w);
        check("IF_ID_Write",   if_id_write,   e.ifid_w);
        check("IF_ID_Flush",   if_id_flush,   e.ifid_f);
        check("ID_EX_Write",   id_ex_write,   e.idex_w);
        check("ID_EX_Flush",   id_ex_flush,   e.idex_f);
        check("EX_MEM_Write",  ex_mem_write,  e.exmem_w);
        check("MEM_WB_Bubble", mem_wb_bubble, e.bub);
        check("Mem_timeout",   mem_timeout,   e.tmo);
        check("Stall_cnt",     stall_cnt,     e.stall_cnt);
        check("Flush_cnt",     flush_cnt,     e.flush_cnt);
      end
    end
  end

  initial begin : driver
    model_reset();
    @(posedge clk); #1;
    // Reset state with a pending load-use hazard on the inputs.
    do_reset(0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);

    // Load-use on rs: one bubble, then masked.
    step(0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    step(0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // RD=0 never hazards; rt compare only when rt is read.
    step(0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    step(0, 1, 0, 1, 5'd7, 5'd1, 5'd7, 0);
    step(0, 1, 0, 1, 5'd7, 5'd1, 5'd7, 1);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // Branch wins over load-use.
    step(0, 1, 1, 1, 5'd9, 5'd9, 5'd9, 1);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // Memory stall hides a taken branch until release.
    repeat (3) step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    // Load-use arriving under a memory stall, then released.
    repeat (2) step(1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    repeat (2) step(0, 1, 0, 1, 5'd3, 5'd3, 5'd0, 0);

    // Randomized traffic over a small register range to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 50),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Timeout watchdog: 256 stalled cycles, then release; sticky until reset.
    do_reset(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (MEM_TIMEOUT) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("timeout_not_yet", mem_timeout, 0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("timeout_set", mem_timeout, 1);
    repeat (4) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("timeout_sticky", mem_timeout, 1);
    do_reset(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("timeout_cleared", mem_timeout, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);

    // Saturation of the stall counter.
    do_reset(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (CNT_MAX - 1) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("stall_cnt_preload", stall_cnt, CNT_MAX - 1);
    repeat (3) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("stall_cnt_saturated", stall_cnt, CNT_MAX);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_hazard_ctrl_unit

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  - MEM_TIMEOUT, 255, max data-memory wait cycles before error.
  - CNT_W, 16, perf counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  - clk_i  in  1  single clock; all state on rising edge.
  - rst_ni  in  1  asynchronous, active-low reset.
  - ID_EX_MemRead_i  in  1  instruction in EX is a load.
  - ID_EX_RD_i  in  5  destination of instruction in EX.
  - IF_ID_RS_i  in  5  rs of instruction in ID.
  - IF_ID_RT_i  in  5  rt of instruction in ID.
  - IF_ID_UsesRT_i  in  1  ID instruction reads rt.
  - Branch_taken_i  in  1  branch/jump resolved taken in EX.
  - EX_MEM_MemAccess_i  in  1  MEM stage holds load/store.
  - DMEM_ready_i  in  1  data memory completes access this cycle.
  - PC_Write_o  out  1  PC update enable.
  - IF_ID_Write_o  out  1  IF/ID register enable.
  - IF_ID_Flush_o  out  1  IF/ID clear to NOP.
  - ID_EX_Write_o  out  1  ID/EX register enable.
  - ID_EX_Flush_o  out  1  ID/EX load bubble (RegWrite/MemRead/MemWrite=0).
  - EX_MEM_Write_o  out  1  EX/MEM register enable.
  - MEM_WB_Bubble_o  out  1  MEM/WB loads bubble.
  - Mem_timeout_o  out  1  sticky memory-timeout error.
  - Stall_cnt_o  out  CNT_W  saturating stall-cycle count.
  - Flush_cnt_o  out  CNT_W  saturating flush-event count.

Function
REQ-003 mem_stall = EX_MEM_MemAccess_i && !DMEM_ready_i; it SHALL have the highest priority.
REQ-004 On mem_stall: PC_Write_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o = 0; MEM_WB_Bubble_o = 1; both flushes = 0, all combinational, same cycle.
REQ-005 Branch_taken_i during mem_stall SHALL be ignored; the frozen EX branch is re-evaluated on the release cycle.
REQ-006 load_use = ID_EX_MemRead_i && ID_EX_RD_i != 0 && (ID_EX_RD_i == IF_ID_RS_i || (IF_ID_UsesRT_i && ID_EX_RD_i == IF_ID_RT_i)).
REQ-007 No mem_stall and Branch_taken_i: IF_ID_Flush_o = 1, ID_EX_Flush_o = 1, all write enables = 1; load_use ignored.
REQ-008 No mem_stall, no branch, load_use: PC_Write_o = 0, IF_ID_Write_o = 0, ID_EX_Flush_o = 1; other enables = 1.
REQ-009 Otherwise: all enables = 1, flushes = 0, MEM_WB_Bubble_o = 0.
REQ-010 A registered flag load_bubble_q SHALL be set on a load_use cycle; while set, load_use SHALL be masked, so at most one bubble is inserted per load.
REQ-011 FSM states SHALL be RUN and MEM_WAIT:
  - RUN->MEM_WAIT on mem_stall.
  - MEM_WAIT->RUN when mem_stall is deasserted.
  - Wait counter is cleared on entry and incremented each MEM_WAIT cycle.
REQ-012 When the wait counter reaches MEM_TIMEOUT, Mem_timeout_o SHALL set and hold until reset; stall outputs still follow REQ-004.
REQ-013 Stall_cnt_o SHALL increment each cycle PC_Write_o == 0; Flush_cnt_o SHALL increment each cycle IF_ID_Flush_o == 1; both SHALL saturate at all-ones and never wrap.
REQ-014 Stall/flush outputs SHALL be combinational with zero latency; counters and flags update on the next edge.

Reset
REQ-015 rst_ni low SHALL asynchronously force:
  - state = RUN; wait counter, load_bubble_q, Mem_timeout_o, Stall_cnt_o, Flush_cnt_o = 0.
  - Combinational outputs follow inputs from the RUN state.
REQ-016 Reset during MEM_WAIT SHALL abandon the wait and clear the timeout progress.

Structure
REQ-017 The shared package SHALL hold the state enum (RUN, MEM_WAIT), the MEM_TIMEOUT default and the CNT_W default.
REQ-018 A single sub-module, sat_counter (param WIDTH; inc, count), SHALL implement both perf counters.

Verification
REQ-019 Load with RD=5 in EX, ID RS=5 -> one cycle PC_Write_o=0, ID_EX_Flush_o=1; next cycle normal; Stall_cnt_o=1.
REQ-020 Load with RD=0 in EX, ID RS=0 -> no stall; load RD=7, IF_ID_RT_i=7, IF_ID_UsesRT_i=0 -> no stall.
REQ-021 Branch_taken_i and load_use in the same cycle -> both flushes=1, PC_Write_o=1; Flush_cnt_o increments by 1.
REQ-022 EX_MEM_MemAccess_i=1, DMEM_ready_i=0 for 3 cycles with Branch_taken_i=1 -> 3 full-stall cycles, flushes=0; 4th cycle flushes=1.
REQ-023 DMEM_ready_i held 0 for 256 cycles -> Mem_timeout_o rises after MEM_TIMEOUT wait cycles and stays high after ready; rst_ni pulse clears it.
REQ-024 Preload 65534 stall cycles, then 3 more -> Stall_cnt_o saturates at 65535.
